// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Collects single-cycle button pulses into pending requests, grants them
// round-robin onto a valid/ready event port, enforces a holdoff gap after
// each accepted event, and counts cycles in which a pulse was lost because
// its request was already pending.
//
// Handshake: evt_valid_o is high only in PRESENT and evt_idx_o is stable
// while it is high; the event transfers on a rising edge where both
// evt_valid_o and evt_ready_i are high. evt_valid_o never depends
// combinationally on evt_ready_i.
module button_event_arbiter #(
   parameter int NUM_BTN = 4,
   parameter int IDX_W   = 2,
   parameter int HOLDOFF = 3,
   parameter int DROP_W  = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_BTN-1:0] btn_pulse_i,
   input  logic               evt_ready_i,
   input  logic               clr_drop_i,
   output logic               evt_valid_o,
   output logic [IDX_W-1:0]   evt_idx_o,
   output logic [NUM_BTN-1:0] pending_o,
   output logic [DROP_W-1:0]  drop_cnt_o,
   output logic [1:0]         state_o
);

   // Holdoff counter must be able to hold HOLDOFF; keep at least one bit.
   localparam int CNT_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;
   logic [NUM_BTN-1:0] pending_q, pending_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [NUM_BTN-1:0] grant_vec;
   logic [NUM_BTN-1:0] drop_vec;
   logic               any_drop;
   logic [IDX_W-1:0]   next_ptr;

   // Round-robin search: first pending bit starting at rr_ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int off = 0; off < NUM_BTN; off++) begin
         if (!sel_found && pending_q[(int'(rr_ptr_q) + off) % NUM_BTN]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'((int'(rr_ptr_q) + off) % NUM_BTN);
         end
      end
   end

   // Pointer value after the presented index, wrapping at NUM_BTN.
   always_comb begin
      if (int'(evt_idx_q) == NUM_BTN - 1) next_ptr = '0;
      else                                next_ptr = evt_idx_q + IDX_W'(1);
   end

   // State register plus the datapath registers the FSM owns.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         evt_idx_q  <= '0;
         pending_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         evt_idx_q  <= evt_idx_d;
         pending_q  <= pending_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Next-state logic: grant in IDLE, wait for accept in PRESENT, count down in HOLD.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_ptr_d  = rr_ptr_q;
      evt_idx_d = evt_idx_q;
      grant_vec = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_vec = NUM_BTN'(1) << sel_idx;
               evt_idx_d = sel_idx;
               state_d   = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (evt_ready_i) begin
               rr_ptr_d = next_ptr;
               if (HOLDOFF == 0) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = CNT_W'(HOLDOFF);
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // Leaving on cnt==1 makes the stay exactly HOLDOFF cycles long.
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Request latching and drop accounting; a pulse on the bit being granted re-arms it.
   always_comb begin
      drop_vec  = btn_pulse_i & pending_q & ~grant_vec;
      any_drop  = |drop_vec;
      pending_d = (pending_q & ~grant_vec) | btn_pulse_i;
      if (clr_drop_i) begin
         drop_cnt_d = any_drop ? DROP_W'(1) : '0;
      end else if (any_drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Outputs decoded from registered state.
   always_comb begin
      evt_valid_o = (state_q == S_PRESENT);
      evt_idx_o   = evt_idx_q;
      pending_o   = pending_q;
      drop_cnt_o  = drop_cnt_q;
      state_o     = state_q;
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed and random bench for button_event_arbiter against a cycle model
// that tracks requests as a bit set, the current grant and a remaining-gap count.
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int H = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn = '0;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_idx;
  logic [N-1:0]  pending;
  logic [DW-1:0] drop_cnt;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] mp;
  int rr, phase, cur, gap, dcnt;  // phase: 0 idle, 1 presenting, 2 gap

  button_event_arbiter #(.NUM_BTN(N), .IDX_W(2), .HOLDOFF(H), .DROP_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .btn_pulse_i(btn), .evt_ready_i(rdy),
    .clr_drop_i(clr), .evt_valid_o(evt_valid), .evt_idx_o(evt_idx),
    .pending_o(pending), .drop_cnt_o(drop_cnt), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mp = '0; rr = 0; phase = 0; cur = 0; gap = 0; dcnt = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] p, input logic r, input logic c);
    int g;
    bit dropped;
    g = -1;
    if (phase == 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && mp[(rr + k) % N]) g = (rr + k) % N;
    dropped = 0;
    for (int i = 0; i < N; i++)
      if (p[i] && mp[i] && i != g) dropped = 1;
    if (c) dcnt = dropped ? 1 : 0;
    else if (dropped && dcnt < (1 << DW) - 1) dcnt++;
    if (g >= 0) mp[g] = 1'b0;
    mp = mp | p;
    case (phase)
      0: if (g >= 0) begin phase = 1; cur = g; end
      1: if (r) begin
           rr = (cur + 1) % N;
           if (H == 0) phase = 0;
           else begin gap = H; phase = 2; end
         end
      default: begin gap--; if (gap == 0) phase = 0; end
    endcase
  endtask

  task automatic compare_all();
    chk("evt_valid", 32'(evt_valid), 32'(phase == 1));
    chk("evt_idx", 32'(evt_idx), 32'(cur));
    chk("pending", 32'(pending), 32'(mp));
    chk("drop_cnt", 32'(drop_cnt), 32'(dcnt));
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic step(input logic [N-1:0] p, input logic r, input logic c);
    btn = p; rdy = r; clr = c;
    @(posedge clk);
    model_edge(p, r, c);
    #1;
    btn = '0; clr = 1'b0;
    compare_all();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic apply_reset(input logic [N-1:0] p);
    btn = p;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid_now", 32'(evt_valid), 32'd0);
    chk("rst_pending_now", 32'(pending), 32'd0);
    chk("rst_drop_now", 32'(drop_cnt), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    btn = '0;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    // Test 1: reset held with all pulses high
    apply_reset(4'b1111);

    // Test 2: single pulse on button 2
    step(4'b0100, 1'b1, 1'b0);
    chk("t2_pending_set", 32'(pending), 32'h4);
    step(4'b0000, 1'b1, 1'b0);
    chk("t2_valid", 32'(evt_valid), 32'd1);
    chk("t2_idx", 32'(evt_idx), 32'd2);
    step(4'b0000, 1'b1, 1'b0);
    chk("t2_one_cycle", 32'(evt_valid), 32'd0);
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    // Test 3: three buttons at once, holdoff gaps between grants
    apply_reset(4'b0000);
    step(4'b1011, 1'b1, 1'b0);
    repeat (16) step(4'b0000, 1'b1, 1'b0);

    // Test 4: stalled consumer, repeated pulses, drop clear priority
    apply_reset(4'b0000);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t4_idx1", 32'(evt_idx), 32'd1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    chk("t4_drop1", 32'(drop_cnt), 32'd1);
    chk("t4_pend1", 32'(pending), 32'h2);
    chk("t4_still_valid", 32'(evt_valid), 32'd1);
    step(4'b0010, 1'b0, 1'b1);
    chk("t4_clr_with_drop", 32'(drop_cnt), 32'd1);
    step(4'b0000, 1'b0, 1'b1);
    chk("t4_clr_alone", 32'(drop_cnt), 32'd0);
    repeat (12) step(4'b0000, 1'b1, 1'b0);

    // Test 5: two buttons hammering every cycle
    apply_reset(4'b0000);
    repeat (24) step(4'b0011, 1'b1, 1'b0);

    // Drop counter saturation
    apply_reset(4'b0000);
    step(4'b0001, 1'b0, 1'b0);
    repeat (262) step(4'b0001, 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'hff);
    step(4'b0000, 1'b0, 1'b1);
    chk("sat_clr", 32'(drop_cnt), 32'd0);

    // Test 6: reset while presenting index 3, then pointer restarts at 0
    apply_reset(4'b0000);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t6_idx3", 32'(evt_idx), 32'd3);
    apply_reset(4'b0000);
    step(4'b1001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t6_first_idx0", 32'(evt_idx), 32'd0);
    chk("t6_valid", 32'(evt_valid), 32'd1);
    repeat (12) step(4'b0000, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] p;
      logic r, c;
      p = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      step(p, r, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
